// File: rtl/queue_if.sv
// queue_if: producer/consumer bundle for the 8-entry FIFO queue
interface queue_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
);
    logic             enq;
    logic             deq;
    logic [WIDTH-1:0] value_in;
    logic [WIDTH-1:0] value_out;
    logic             empty;
    logic             full;
    logic [AW:0]      count;
    logic             ovf;
    logic             udf;
    modport master (
        output enq, deq, value_in,
        input  value_out, empty, full, count, ovf, udf
    );
    modport slave (
        input  enq, deq, value_in,
        output value_out, empty, full, count, ovf, udf
    );
endinterface

// File: rtl/queue.sv
// queue: 8x16 FIFO with zero-latency head read and sticky overflow/underflow flags
module queue #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
) (
    input  logic   clk,
    input  logic   reset,
    queue_if.slave q
);
    localparam int DEPTH = 2 ** AW;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [AW:0]      count_q, count_d;
    logic             ovf_q, ovf_d, udf_q, udf_d;
    logic             empty, full, deq_ok, enq_ok;
    assign empty       = count_q == '0;
    assign full        = count_q == DEPTH[AW:0];
    assign q.empty     = empty;
    assign q.full      = full;
    assign q.count     = count_q;
    assign q.ovf       = ovf_q;
    assign q.udf       = udf_q;
    assign q.value_out = empty ? '0 : mem_q[head_q];
    // Accept decisions and next pointer/count/flag state; a full queue still takes a write when the head is freed the same edge
    always_comb begin
        deq_ok  = q.deq & ~empty;
        enq_ok  = q.enq & (~full | deq_ok);
        head_d  = deq_ok ? head_q + AW'(1) : head_q;
        tail_d  = enq_ok ? tail_q + AW'(1) : tail_q;
        count_d = (enq_ok & ~deq_ok) ? count_q + 1'b1 :
                  (deq_ok & ~enq_ok) ? count_q - 1'b1 : count_q;
        ovf_d   = ovf_q | (q.enq & full & ~q.deq);
        udf_d   = udf_q | (q.deq & empty & ~q.enq);
    end
    // State registers and storage; retired words stay in memory untouched
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (enq_ok) mem_q[tail_q] <= q.value_in;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end
endmodule
